exception_sequencer: RTL
========================

# exception_sequencer

Multicycle control sequencer that owns the write-back and PC-redirect datapath during two special sequences: post-reset stack-pointer initialisation and exception entry. It sits beside the main control unit. While `override` is high, its `memtoreg`, `reg_write`, `write_reg`, `pc_write`, `pc_src_exc`, `epc_write`, `mem_read` and `mem_addr` outputs replace the main control's outputs at the top-level select. It produces `exc_addr`, which feeds the exception-address input of the write-back mux and the PC-source mux.

## Interface
- `VEC_BASE`, 253: byte address of the first exception vector; vector = `VEC_BASE + exc_code`
- `SP_INIT`, 227: constant selected by memtoreg code 010 (value fixed in the write-back mux; listed here for test reference)
- `SP_REG`, 29: register index written during init
- `MEM_LAT`, 1: memory read wait cycles, legal range 1..3
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `exc_req` in 1: exception request from main control, level-sampled in IDLE
- `exc_code` in 2: 00 invalid opcode, 01 overflow, 10 divide-by-zero, 11 reserved
- `mem_rdata` in 8: low byte of memory read data
- `override` out 1: block owns the datapath controls
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse on the PC redirect cycle
- `reg_write` out 1: register file write enable
- `write_reg` out 5: register file write index
- `memtoreg` out 3: write-back mux select
- `epc_write` out 1: EPC load enable
- `mem_read` out 1: memory read enable
- `mem_addr` out 32: memory address
- `exc_addr` out 32: zero-extended vector byte, registered
- `pc_write` out 1: PC load enable
- `pc_src_exc` out 1: PC source = `exc_addr`

## Operation
- States: INIT_SP, IDLE, EPC_SAVE, MEM_WAIT, VEC_LOAD, JUMP.
- Outputs are Moore, decoded from state. Outputs not listed for a state are 0. `write_reg` is 0 and `memtoreg` is 000 unless listed.
- INIT_SP: `override`=1, `reg_write`=1, `write_reg`=`SP_REG`, `memtoreg`=010. Always goes to IDLE next.
- IDLE: `override`=0. If `exc_req`=1 and `exc_code`≠11, latch `exc_code` into `code_q` and go to EPC_SAVE. Otherwise stay in IDLE. Code 11 is ignored with no state change.
- EPC_SAVE: `override`=1, `epc_write`=1, `mem_read`=1, `mem_addr`=`VEC_BASE`+`code_q`. Load the wait counter with `MEM_LAT`−1 and go to MEM_WAIT.
- MEM_WAIT: `override`=1, `mem_read`=1, `mem_addr` held. Decrement the counter; go to VEC_LOAD when the counter is 0.
- VEC_LOAD: `override`=1, `mem_addr` held. At the end of this cycle, `exc_addr` ← {24'b0, `mem_rdata`}. Go to JUMP.
- JUMP: `override`=1, `pc_write`=1, `pc_src_exc`=1, `done`=1. Go to IDLE.
- `exc_req` outside IDLE is ignored and not queued; main control must hold or re-raise it.
- `exc_addr` holds its value until the next VEC_LOAD.

## Timing
- `reset`=1 at an edge: state ← INIT_SP, `exc_addr` ← 0, `code_q` ← 00, counter ← 0. This applies from any state, including mid-sequence. A partial exception is abandoned and no `pc_write` occurs.
- Reset values of outputs, since the state is INIT_SP: `override`=1, `reg_write`=1, `write_reg`=29, `memtoreg`=010; all others 0; `exc_addr`=0. The register file's own reset has priority during reset cycles.
- After `reset` falls, INIT_SP lasts exactly one cycle, and the `$29` write commits at that edge. IDLE follows.
- Exception latency: `exc_req` sampled at edge 0 → EPC_SAVE in cycle 1 → MEM_WAIT in cycles 2..1+`MEM_LAT` → VEC_LOAD in cycle 2+`MEM_LAT` → JUMP with `done` in cycle 3+`MEM_LAT` → IDLE in cycle 4+`MEM_LAT`.
- `exc_req` held high in IDLE restarts the sequence immediately, with a minimum of one IDLE cycle between sequences.
- `mem_addr` is stable from EPC_SAVE through VEC_LOAD.

## Test plan
- Reset for 3 cycles, then release → for 1 cycle `reg_write`=1, `write_reg`=29, `memtoreg`=010, `override`=1; next cycle IDLE with `busy`=0.
- Overflow: `exc_req`=1, `exc_code`=01, `mem_rdata`=0x80, `MEM_LAT`=1 → `epc_write` in cycle 1, `mem_addr`=254 in cycles 1–3, `done`/`pc_write`/`pc_src_exc` in cycle 4, `exc_addr`=0x00000080.
- Divide-by-zero with `MEM_LAT`=3 and `mem_rdata`=0xFF → `mem_addr`=255, `done` in cycle 6, `exc_addr`=0x000000FF.
- `exc_code`=11 in IDLE → no state change, `busy` stays 0. Second `exc_req` pulse during MEM_WAIT → ignored, exactly one `done`.
- Reset asserted during MEM_WAIT → next cycle INIT_SP, `exc_addr`=0, no `pc_write` pulse.
- Invalid opcode (`exc_code`=00, `mem_rdata`=0x10) followed by a held `exc_req` → two complete sequences with `mem_addr`=253, one IDLE cycle between them, `exc_addr`=0x10.

Source files
------------

// File: rtl/exception_sequencer.sv
// Sequencer that owns the write-back and PC-redirect controls during post-reset
// stack-pointer init and exception entry. All outputs are registered Moore decodes.
module exception_sequencer #(
  parameter int VEC_BASE = 253,
  parameter int SP_REG   = 29,
  parameter int MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_req,
  input  logic [1:0]  exc_code,
  input  logic [7:0]  mem_rdata,
  output logic        override,
  output logic        busy,
  output logic        done,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [2:0]  memtoreg,
  output logic        epc_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] exc_addr,
  output logic        pc_write,
  output logic        pc_src_exc,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    INIT_SP  = 3'd0,
    IDLE     = 3'd1,
    EPC_SAVE = 3'd2,
    MEM_WAIT = 3'd3,
    VEC_LOAD = 3'd4,
    JUMP     = 3'd5
  } state_t;

  state_t      state, nxt, tgt;
  logic [1:0]  code_q, nxt_code, tgt_code;
  logic [1:0]  cnt;

  logic        d_override, d_busy, d_done, d_reg_write, d_epc_write;
  logic        d_mem_read, d_pc_write, d_pc_src_exc;
  logic [4:0]  d_write_reg;
  logic [2:0]  d_memtoreg;
  logic [31:0] d_mem_addr;

  assign state_dbg = state;

  // Next state, then the outputs that state will present. Decoding the target
  // state (reset folded in) lets every output be a plain register.
  always_comb begin
    nxt      = state;
    nxt_code = code_q;
    unique case (state)
      INIT_SP:  nxt = IDLE;
      IDLE: begin
        if (exc_req && exc_code != 2'b11) begin
          nxt      = EPC_SAVE;
          nxt_code = exc_code;
        end
      end
      EPC_SAVE: nxt = MEM_WAIT;
      MEM_WAIT: if (cnt == 2'd0) nxt = VEC_LOAD;
      VEC_LOAD: nxt = JUMP;
      JUMP:     nxt = IDLE;
      default:  nxt = INIT_SP;
    endcase

    tgt      = reset ? INIT_SP : nxt;
    tgt_code = reset ? 2'b00 : nxt_code;

    d_override   = 1'b0;
    d_busy       = (tgt != IDLE);
    d_done       = 1'b0;
    d_reg_write  = 1'b0;
    d_write_reg  = 5'd0;
    d_memtoreg   = 3'b000;
    d_epc_write  = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_addr   = 32'd0;
    d_pc_write   = 1'b0;
    d_pc_src_exc = 1'b0;
    unique case (tgt)
      INIT_SP: begin
        d_override  = 1'b1;
        d_reg_write = 1'b1;
        d_write_reg = 5'(SP_REG);
        d_memtoreg  = 3'b010;
      end
      EPC_SAVE: begin
        d_override  = 1'b1;
        d_epc_write = 1'b1;
        d_mem_read  = 1'b1;
        d_mem_addr  = 32'(VEC_BASE) + {30'd0, tgt_code};
      end
      MEM_WAIT: begin
        d_override = 1'b1;
        d_mem_read = 1'b1;
        d_mem_addr = 32'(VEC_BASE) + {30'd0, tgt_code};
      end
      VEC_LOAD: begin
        d_override = 1'b1;
        d_mem_addr = 32'(VEC_BASE) + {30'd0, tgt_code};
      end
      JUMP: begin
        d_override   = 1'b1;
        d_pc_write   = 1'b1;
        d_pc_src_exc = 1'b1;
        d_done       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    state      <= tgt;
    code_q     <= tgt_code;
    override   <= d_override;
    busy       <= d_busy;
    done       <= d_done;
    reg_write  <= d_reg_write;
    write_reg  <= d_write_reg;
    memtoreg   <= d_memtoreg;
    epc_write  <= d_epc_write;
    mem_read   <= d_mem_read;
    mem_addr   <= d_mem_addr;
    pc_write   <= d_pc_write;
    pc_src_exc <= d_pc_src_exc;
    if (reset) begin
      cnt      <= 2'd0;
      exc_addr <= 32'd0;
    end else begin
      if (state == EPC_SAVE)
        cnt <= 2'(MEM_LAT - 1);
      else if (state == MEM_WAIT && cnt != 2'd0)
        cnt <= cnt - 2'd1;
      if (state == VEC_LOAD)
        exc_addr <= {24'd0, mem_rdata};
    end
  end

endmodule
